memory_access: RTL and testbench
================================

# memory_access

- Memory stage of the five-stage RV64 pipeline; sits directly downstream of execute and consumes its `execute_data_t` output.
- Turns load/store control into data-bus requests over the `dbus_req_t`/`dbus_resp_t` handshake and aligns store data.
- Extracts and extends load data and produces `memory_data_t` for writeback.
- Holds the upstream pipeline with a stall until the bus transaction completes.

## Interface
Parameters: none. Widths come from the shared packages: `word_t` is 64 bits and `addr_t` is 64 bits.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `dataE` in `execute_data_t`: uses `valid`, `pc`, `raw_instr`, `dst`, `aluout` (address or result), `memwd` (store data) and `ctl`.
  - Relevant `ctl` fields: `memread`, `memwrite`, `msize` (`msize_t`: B/H/W/D), `memunsigned`.
- `dreq` out `dbus_req_t`: fields `valid`, `addr`, `size`, `strobe[7:0]`, `data`.
- `dresp` in `dbus_resp_t`: fields `data_ok`, `data`.
- `dataM` out `memory_data_t`: fields `valid`, `pc`, `raw_instr`, `dst`, `ctl`, `result`, `misalign`.
- `stallM` out 1: freezes the pipeline registers upstream of this stage.

## Operation
- A memory op is `dataE.valid & (memread | memwrite)`.
- Non-memory or invalid input:
  - `dataM` passes through combinationally, with `result = aluout`.
  - `stallM = 0` and `dreq.valid = 0`.
- FSM states:
  - **IDLE**
    - On a memory op: go to BUSY, assert `stallM` combinationally, and register `addr`, `size`, `strobe` and aligned data.
    - `dataM.valid = 0` this cycle.
  - **BUSY**
    - `dreq.valid = 1`; `dreq` fields are stable from registers.
    - `stallM = 1`, `dataM.valid = 0`.
    - When `dresp.data_ok = 1`: latch `dresp.data` and go to DONE.
  - **DONE**
    - `stallM = 0`, `dreq.valid = 0`.
    - `dataM.valid = 1`; `result` is the extended load value, or `aluout` for a store.
    - Unconditionally return to IDLE. The upstream register advances on this edge, so the op is never reissued.
- Store alignment, with `off = addr[2:0]`:
  - `data = memwd << (8*off)`.
  - `strobe = mask(msize) << off`, where `mask` is B=0x01, H=0x03, W=0x0F, D=0xFF.
- Load extraction:
  - `raw = rdata >> (8*off)`.
  - Truncate `raw` to the size, then sign-extend, or zero-extend when `memunsigned`.
- `dreq.size` equals `ctl.msize`. `dreq.addr` is the full `aluout`; it is not aligned down.

## Timing
- Memory op latency is 3 cycles minimum when `data_ok` arrives in the first BUSY cycle: IDLE → BUSY → DONE.
- Each extra cycle of `data_ok` delay adds one cycle.
- Non-memory ops take 0 added cycles.
- Reset values:
  - State is IDLE.
  - `dreq` is all zero.
  - `stallM = 0`.
  - `dataM.valid = 0`.
  - All internal registers are 0.
- Reset during BUSY: next cycle is IDLE with `dreq.valid = 0`. A late `data_ok` arriving in IDLE is ignored.
- `data_ok` arriving in IDLE or DONE is ignored.
- `dataE` changing while `stallM = 1` is a protocol violation upstream; the registered request is used regardless.
- A memory op arriving in the cycle right after DONE is accepted normally (IDLE → BUSY).

## Configuration
- `MEM_MISALIGN_EN` defined:
  - A memory op whose address is not a multiple of its access size (`addr & (size_bytes-1) != 0`) skips BUSY: IDLE → DONE.
  - No bus request is issued.
  - DONE outputs `misalign = 1`, `result = aluout`, and `ctl.regwrite` forced to 0.
- `MEM_MISALIGN_EN` undefined:
  - No check is made; `misalign` is tied to 0.
  - The request is issued as-is. Strobe bits shifted beyond bit 7 are dropped.

## Structure
- `pipes` package holds `memory_data_t` and `msize_t`.
- `common` package holds `dbus_req_t`, `dbus_resp_t` and `word_t`.
- Sub-module `memalign`: combinational store shift/strobe and load shift/extend, taking `off`, `msize` and `memunsigned`.
- The FSM and registers stay in `memory_access`.

## Test plan
- **SD:** `aluout = 0x80000010`, `memwd = 0x1122334455667788`, D size, `data_ok` one cycle late.
  - `dreq.valid` held 2 cycles with addr 0x80000010, strobe 0xFF, data unchanged.
  - `stallM` high 3 cycles, then `dataM.valid` for 1 cycle.
- **SB:** `aluout = 0x80000013`, `memwd = 0xAB` → strobe 0x08, data 0x00000000AB000000.
- **LB:** addr offset 6, `rdata = 0x00F0000000000000`.
  - Signed: `result = 0xFFFFFFFFFFFFFFF0`.
  - `memunsigned`: `result = 0xF0`.
- **LW:** addr offset 4, `rdata = 0x8000000100000000` → `result = 0xFFFFFFFF80000001`.
- **Reset in BUSY:** assert `reset` while BUSY with `data_ok` low, then pulse `data_ok` in the next cycle.
  - Expect IDLE, `dreq.valid = 0`, `stallM = 0`, no `dataM.valid`.
- **Misalign:** `MEM_MISALIGN_EN` defined, LW at 0x80000002.
  - No `dreq.valid`.
  - `dataM.valid` with `misalign = 1` exactly 2 cycles after acceptance.
- **Back-to-back:** ADD, then LD, then ADD.
  - ADD passes with `stallM = 0`.
  - LD stalls until DONE.
  - Following ADD passes in the cycle after DONE.

Source files
------------

// File: rtl/memory_access_pkg.sv
// memory_access_pkg
//   Shared types for the RV64 memory stage: machine word/address types,
//   access size encoding, the execute->memory and memory->writeback
//   pipeline records, the data-bus request/response records and the
//   memory-stage FSM state encoding. Also holds small helpers that map an
//   access size to its byte-enable pattern and its alignment mask.
package memory_access_pkg;

   typedef logic [63:0] word_t;
   typedef logic [63:0] addr_t;
   typedef logic [4:0]  creg_addr_t;

   typedef enum logic [1:0] {
      MSIZE_B = 2'd0,
      MSIZE_H = 2'd1,
      MSIZE_W = 2'd2,
      MSIZE_D = 2'd3
   } msize_t;

   typedef struct packed {
      logic   regwrite;
      logic   memread;
      logic   memwrite;
      msize_t msize;
      logic   memunsigned;
   } control_t;

   typedef struct packed {
      logic       valid;
      addr_t      pc;
      logic [31:0] raw_instr;
      creg_addr_t dst;
      word_t      aluout;
      word_t      memwd;
      control_t   ctl;
   } execute_data_t;

   typedef struct packed {
      logic       valid;
      addr_t      pc;
      logic [31:0] raw_instr;
      creg_addr_t dst;
      control_t   ctl;
      word_t      result;
      logic       misalign;
   } memory_data_t;

   typedef struct packed {
      logic       valid;
      addr_t      addr;
      msize_t     size;
      logic [7:0] strobe;
      word_t      data;
   } dbus_req_t;

   typedef struct packed {
      logic  data_ok;
      word_t data;
   } dbus_resp_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Byte enables of an access placed at offset 0.
   function automatic logic [7:0] size_strobe(input msize_t s);
      logic [7:0] m;
      case (s)
         MSIZE_B: m = 8'h01;
         MSIZE_H: m = 8'h03;
         MSIZE_W: m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] size_align_mask(input msize_t s);
      logic [2:0] m;
      case (s)
         MSIZE_B: m = 3'b000;
         MSIZE_H: m = 3'b001;
         MSIZE_W: m = 3'b011;
         default: m = 3'b111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/memory_access_memalign.sv
// memory_access_memalign
//   Purely combinational lane steering for the memory stage.
//   Store side: shifts store data into its byte lanes and builds the byte
//   strobe for the access size; strobe bits pushed past lane 7 fall off.
//   Load side: shifts the returned bus word down by the address offset,
//   truncates to the access size and sign- or zero-extends it.
//   Ports:
//     st_off, st_msize, st_wdata   store offset, size and unaligned data
//     st_data, st_strobe           lane-aligned store data and byte enables
//     ld_off, ld_msize, ld_unsigned, ld_rdata   load offset/size/ext/bus word
//     ld_result                    extended load value
module memory_access_memalign
   import memory_access_pkg::*;
(
   input  logic [2:0] st_off,
   input  msize_t     st_msize,
   input  word_t      st_wdata,
   output word_t      st_data,
   output logic [7:0] st_strobe,
   input  logic [2:0] ld_off,
   input  msize_t     ld_msize,
   input  logic       ld_unsigned,
   input  word_t      ld_rdata,
   output word_t      ld_result
);

   word_t ld_raw;

   assign st_data   = st_wdata << {st_off, 3'b000};
   // 8-bit result context: lanes beyond 7 are discarded.
   assign st_strobe = size_strobe(st_msize) << st_off;

   assign ld_raw    = ld_rdata >> {ld_off, 3'b000};

   always_comb begin
      ld_result = ld_raw;
      case (ld_msize)
         MSIZE_B: ld_result = ld_unsigned ? {56'b0, ld_raw[7:0]}
                                          : {{56{ld_raw[7]}}, ld_raw[7:0]};
         MSIZE_H: ld_result = ld_unsigned ? {48'b0, ld_raw[15:0]}
                                          : {{48{ld_raw[15]}}, ld_raw[15:0]};
         MSIZE_W: ld_result = ld_unsigned ? {32'b0, ld_raw[31:0]}
                                          : {{32{ld_raw[31]}}, ld_raw[31:0]};
         default: ld_result = ld_raw;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// memory_access
//   Memory stage of the five-stage RV64 pipeline. Non-memory instructions
//   pass straight through. A load/store is captured into a registered bus
//   request, the upstream pipeline is stalled while the request is
//   outstanding, and the (extended) result is presented for one DONE cycle.
//   Optional feature macro: MEM_MISALIGN_EN -- when defined, misaligned
//   accesses skip the bus entirely and complete with misalign=1 and
//   regwrite suppressed.
//   Ports:
//     clk, reset   single clock, synchronous active-high reset
//     dataE        record from execute
//     dreq, dresp  data-bus request (registered) and response
//     dataM        record to writeback
//     stallM       holds the pipeline registers upstream of this stage
module memory_access
   import memory_access_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  execute_data_t dataE,
   output dbus_req_t     dreq,
   input  dbus_resp_t    dresp,
   output memory_data_t  dataM,
   output logic          stallM
);

   state_t    state_reg;
   dbus_req_t dreq_reg;
   word_t     rdata_reg;
   logic      is_load_reg;
   logic      unsigned_reg;
   logic      misalign_reg;

   logic       mem_op;
   logic       misalign_now;
   word_t      st_data;
   logic [7:0] st_strobe;
   word_t      ld_result;

   assign mem_op = dataE.valid & (dataE.ctl.memread | dataE.ctl.memwrite);

`ifdef MEM_MISALIGN_EN
   assign misalign_now = |(dataE.aluout[2:0] & size_align_mask(dataE.ctl.msize));
`else
   assign misalign_now = 1'b0;
`endif

   // Store lanes come from the live execute record (captured on accept);
   // load extraction uses the captured request so it stays stable in DONE.
   memory_access_memalign u_memalign (
      .st_off      (dataE.aluout[2:0]),
      .st_msize    (dataE.ctl.msize),
      .st_wdata    (dataE.memwd),
      .st_data     (st_data),
      .st_strobe   (st_strobe),
      .ld_off      (dreq_reg.addr[2:0]),
      .ld_msize    (dreq_reg.size),
      .ld_unsigned (unsigned_reg),
      .ld_rdata    (rdata_reg),
      .ld_result   (ld_result)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         dreq_reg     <= '0;
         rdata_reg    <= '0;
         is_load_reg  <= 1'b0;
         unsigned_reg <= 1'b0;
         misalign_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (mem_op) begin
                  if (misalign_now) begin
                     state_reg    <= ST_DONE;
                     misalign_reg <= 1'b1;
                  end else begin
                     state_reg       <= ST_BUSY;
                     misalign_reg    <= 1'b0;
                     dreq_reg.valid  <= 1'b1;
                     dreq_reg.addr   <= dataE.aluout;
                     dreq_reg.size   <= dataE.ctl.msize;
                     dreq_reg.strobe <= st_strobe;
                     dreq_reg.data   <= st_data;
                  end
                  is_load_reg  <= dataE.ctl.memread;
                  unsigned_reg <= dataE.ctl.memunsigned;
               end
            end
            ST_BUSY: begin
               if (dresp.data_ok) begin
                  rdata_reg      <= dresp.data;
                  dreq_reg.valid <= 1'b0;
                  state_reg      <= ST_DONE;
               end
            end
            default: begin
               // Upstream advances on this edge, so the op cannot be reissued.
               state_reg    <= ST_IDLE;
               misalign_reg <= 1'b0;
            end
         endcase
      end
   end

   assign dreq = dreq_reg;

   // Identity fields come from dataE in every state: upstream is frozen
   // while this stage is BUSY/DONE, so they belong to the op in flight.
   always_comb begin
      dataM.valid     = 1'b0;
      dataM.pc        = dataE.pc;
      dataM.raw_instr = dataE.raw_instr;
      dataM.dst       = dataE.dst;
      dataM.ctl       = dataE.ctl;
      dataM.result    = dataE.aluout;
      dataM.misalign  = 1'b0;
      stallM          = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            dataM.valid = dataE.valid & ~mem_op;
            stallM      = mem_op;
         end
         ST_BUSY: begin
            stallM = 1'b1;
         end
         default: begin
            dataM.valid    = 1'b1;
            dataM.misalign = misalign_reg;
            if (misalign_reg)
               dataM.ctl.regwrite = 1'b0;
            else if (is_load_reg)
               dataM.result = ld_result;
         end
      endcase
   end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
   import memory_access_pkg::*;

   logic          clk = 1'b0;
   logic          reset;
   execute_data_t dataE;
   dbus_req_t     dreq;
   dbus_resp_t    dresp;
   memory_data_t  dataM;
   logic          stallM;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memory_access dut (
      .clk    (clk),
      .reset  (reset),
      .dataE  (dataE),
      .dreq   (dreq),
      .dresp  (dresp),
      .dataM  (dataM),
      .stallM (stallM)
   );

   typedef struct {
      addr_t      addr;
      word_t      wd;
      msize_t     size;
      logic       rd;
      logic       wr;
      logic       uns;
      word_t      rdata;
      logic [7:0] exp_strobe;
      word_t      exp_data;
      word_t      exp_result;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input addr_t a, input word_t wd, input msize_t sz,
                        input logic rd, input logic wr, input logic uns);
      dataE                 = '0;
      dataE.valid           = v;
      dataE.pc              = 64'h0000_0000_8000_1000;
      dataE.raw_instr       = 32'h0000_0013;
      dataE.dst             = 5'd10;
      dataE.aluout          = a;
      dataE.memwd           = wd;
      dataE.ctl.regwrite    = ~wr;
      dataE.ctl.memread     = rd;
      dataE.ctl.memwrite    = wr;
      dataE.ctl.msize       = sz;
      dataE.ctl.memunsigned = uns;
   endtask

   function automatic vec_t mk(input addr_t a, input word_t wd, input msize_t sz, input logic rd,
                               input logic uns, input word_t rdata, input logic [7:0] st,
                               input word_t dat, input word_t res);
      vec_t r;
      r.addr = a; r.wd = wd; r.size = sz; r.rd = rd; r.wr = ~rd; r.uns = uns;
      r.rdata = rdata; r.exp_strobe = st; r.exp_data = dat; r.exp_result = res;
      return r;
   endfunction

   vec_t vecs[10];
   int   stall_cnt;

   initial begin
      vecs[0] = mk(64'h8000_0010, 64'h1122_3344_5566_7788, MSIZE_D, 0, 0, 64'h0,
                   8'hFF, 64'h1122_3344_5566_7788, 64'h8000_0010);
      vecs[1] = mk(64'h8000_0013, 64'hAB, MSIZE_B, 0, 0, 64'h0,
                   8'h08, 64'h0000_0000_AB00_0000, 64'h8000_0013);
      vecs[2] = mk(64'h8000_0006, 64'h0, MSIZE_B, 1, 0, 64'h00F0_0000_0000_0000,
                   8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0);
      vecs[3] = mk(64'h8000_0006, 64'h0, MSIZE_B, 1, 1, 64'h00F0_0000_0000_0000,
                   8'h00, 64'h0, 64'h0000_0000_0000_00F0);
      vecs[4] = mk(64'h8000_0004, 64'h0, MSIZE_W, 1, 0, 64'h8000_0001_0000_0000,
                   8'h00, 64'h0, 64'hFFFF_FFFF_8000_0001);
      vecs[5] = mk(64'h8000_0006, 64'hBEEF, MSIZE_H, 0, 0, 64'h0,
                   8'hC0, 64'hBEEF_0000_0000_0000, 64'h8000_0006);
      vecs[6] = mk(64'h8000_0002, 64'h0, MSIZE_H, 1, 0, 64'hFFFF_FFFF_8234_FFFF,
                   8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8234);
      vecs[7] = mk(64'h8000_0024, 64'hDEAD_BEEF_CAFE_F00D, MSIZE_W, 0, 0, 64'h0,
                   8'hF0, 64'hCAFE_F00D_0000_0000, 64'h8000_0024);
      vecs[8] = mk(64'h8000_0008, 64'h0, MSIZE_D, 1, 0, 64'h0123_4567_89AB_CDEF,
                   8'h00, 64'h0, 64'h0123_4567_89AB_CDEF);
      vecs[9] = mk(64'h8000_0000, 64'h0, MSIZE_W, 1, 1, 64'hFFFF_FFFF_8765_4321,
                   8'h00, 64'h0, 64'h0000_0000_8765_4321);

      // ---------------- reset ----------------
      reset = 1'b1;
      dataE = '0;
      dresp = '0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_dreq_valid", 64'(dreq.valid), 64'd0);
      chk("rst_dreq_addr", dreq.addr, 64'd0);
      chk("rst_dreq_strobe", 64'(dreq.strobe), 64'd0);
      chk("rst_dreq_data", dreq.data, 64'd0);
      chk("rst_stallM", 64'(stallM), 64'd0);
      chk("rst_dataM_valid", 64'(dataM.valid), 64'd0);
      $display("txn reset done");

      // ---------------- table: data_ok in first BUSY cycle ----------------
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         drive(1'b1, vecs[i].addr, vecs[i].wd, vecs[i].size, vecs[i].rd, vecs[i].wr, vecs[i].uns);
         dresp = '0;
         @(negedge clk);
         chk($sformatf("v%0d_accept_stall", i), 64'(stallM), 64'd1);
         chk($sformatf("v%0d_accept_valid", i), 64'(dataM.valid), 64'd0);
         chk($sformatf("v%0d_accept_dreq", i), 64'(dreq.valid), 64'd0);
         next_cycle();
         dresp.data_ok = 1'b1;
         dresp.data    = vecs[i].rdata;
         @(negedge clk);
         chk($sformatf("v%0d_busy_dreq", i), 64'(dreq.valid), 64'd1);
         chk($sformatf("v%0d_busy_addr", i), dreq.addr, vecs[i].addr);
         chk($sformatf("v%0d_busy_size", i), 64'(dreq.size), 64'(vecs[i].size));
         chk($sformatf("v%0d_busy_stall", i), 64'(stallM), 64'd1);
         if (vecs[i].wr) begin
            chk($sformatf("v%0d_strobe", i), 64'(dreq.strobe), 64'(vecs[i].exp_strobe));
            chk($sformatf("v%0d_wdata", i), dreq.data, vecs[i].exp_data);
         end
         next_cycle();
         dresp = '0;
         @(negedge clk);
         chk($sformatf("v%0d_done_valid", i), 64'(dataM.valid), 64'd1);
         chk($sformatf("v%0d_done_stall", i), 64'(stallM), 64'd0);
         chk($sformatf("v%0d_done_dreq", i), 64'(dreq.valid), 64'd0);
         chk($sformatf("v%0d_result", i), dataM.result, vecs[i].exp_result);
         chk($sformatf("v%0d_misalign", i), 64'(dataM.misalign), 64'd0);
         $display("txn vec %0d addr %h result %h", i, vecs[i].addr, dataM.result);
         next_cycle();
         dataE = '0;
         @(negedge clk);
         chk($sformatf("v%0d_idle_valid", i), 64'(dataM.valid), 64'd0);
      end

      // ---------------- SD with data_ok one cycle late ----------------
      next_cycle();
      drive(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, MSIZE_D, 1'b0, 1'b1, 1'b0);
      stall_cnt = 0;
      @(negedge clk);
      if (stallM) stall_cnt++;
      next_cycle();
      @(negedge clk);
      if (stallM) stall_cnt++;
      chk("sd_late_dreq1", 64'(dreq.valid), 64'd1);
      next_cycle();
      dresp.data_ok = 1'b1;
      @(negedge clk);
      if (stallM) stall_cnt++;
      chk("sd_late_dreq2", 64'(dreq.valid), 64'd1);
      chk("sd_late_addr", dreq.addr, 64'h8000_0010);
      chk("sd_late_strobe", 64'(dreq.strobe), 64'hFF);
      chk("sd_late_data", dreq.data, 64'h1122_3344_5566_7788);
      chk("sd_late_valid_busy", 64'(dataM.valid), 64'd0);
      next_cycle();
      dresp = '0;
      @(negedge clk);
      chk("sd_late_stall_cycles", 64'(stall_cnt), 64'd3);
      chk("sd_late_done_valid", 64'(dataM.valid), 64'd1);
      chk("sd_late_done_stall", 64'(stallM), 64'd0);
      next_cycle();
      dataE = '0;
      @(negedge clk);
      chk("sd_late_after_valid", 64'(dataM.valid), 64'd0);
      $display("txn sd_late stall_cycles %0d", stall_cnt);

      // ---------------- reset while BUSY ----------------
      next_cycle();
      drive(1'b1, 64'h8000_0008, 64'h0, MSIZE_D, 1'b1, 1'b0, 1'b0);
      next_cycle();
      @(negedge clk);
      chk("rb_busy_dreq", 64'(dreq.valid), 64'd1);
      reset = 1'b1;
      dataE = '0;
      next_cycle();
      reset = 1'b0;
      dresp.data_ok = 1'b1;
      dresp.data    = 64'hDEAD_DEAD_DEAD_DEAD;
      @(negedge clk);
      chk("rb_dreq_valid", 64'(dreq.valid), 64'd0);
      chk("rb_stallM", 64'(stallM), 64'd0);
      chk("rb_dataM_valid", 64'(dataM.valid), 64'd0);
      next_cycle();
      dresp = '0;
      @(negedge clk);
      chk("rb_late_ok_valid", 64'(dataM.valid), 64'd0);
      chk("rb_late_ok_dreq", 64'(dreq.valid), 64'd0);
      $display("txn reset_in_busy");

      // ---------------- misaligned LW at 0x80000002 ----------------
      next_cycle();
      drive(1'b1, 64'h8000_0002, 64'h0, MSIZE_W, 1'b1, 1'b0, 1'b0);
      dataE.ctl.regwrite = 1'b1;
      @(negedge clk);
      chk("mis_accept_stall", 64'(stallM), 64'd1);
      chk("mis_accept_valid", 64'(dataM.valid), 64'd0);
      next_cycle();
`ifdef MEM_MISALIGN_EN
      @(negedge clk);
      chk("mis_no_dreq", 64'(dreq.valid), 64'd0);
      chk("mis_valid", 64'(dataM.valid), 64'd1);
      chk("mis_flag", 64'(dataM.misalign), 64'd1);
      chk("mis_result", dataM.result, 64'h8000_0002);
      chk("mis_regwrite", 64'(dataM.ctl.regwrite), 64'd0);
      chk("mis_stall", 64'(stallM), 64'd0);
`else
      dresp.data_ok = 1'b1;
      dresp.data    = 64'h0000_1234_5678_0000;
      @(negedge clk);
      chk("mis_dreq", 64'(dreq.valid), 64'd1);
      chk("mis_strobe", 64'(dreq.strobe), 64'h3C);
      next_cycle();
      dresp = '0;
      @(negedge clk);
      chk("mis_valid", 64'(dataM.valid), 64'd1);
      chk("mis_flag", 64'(dataM.misalign), 64'd0);
      chk("mis_regwrite", 64'(dataM.ctl.regwrite), 64'd1);
      chk("mis_result", dataM.result, 64'h0000_0000_1234_5678);
`endif
      next_cycle();
      dataE = '0;
      @(negedge clk);
      chk("mis_after_valid", 64'(dataM.valid), 64'd0);
      $display("txn misalign");

      // ---------------- back-to-back ADD, LD, ADD ----------------
      next_cycle();
      drive(1'b1, 64'h0000_1234, 64'h0, MSIZE_D, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b_add1_stall", 64'(stallM), 64'd0);
      chk("b2b_add1_valid", 64'(dataM.valid), 64'd1);
      chk("b2b_add1_result", dataM.result, 64'h0000_1234);
      chk("b2b_add1_dreq", 64'(dreq.valid), 64'd0);
      next_cycle();
      drive(1'b1, 64'h8000_0008, 64'h0, MSIZE_D, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b_ld_stall0", 64'(stallM), 64'd1);
      next_cycle();
      dresp.data_ok = 1'b1;
      dresp.data    = 64'hA5A5_0000_FFFF_0001;
      @(negedge clk);
      chk("b2b_ld_stall1", 64'(stallM), 64'd1);
      next_cycle();
      dresp = '0;
      @(negedge clk);
      chk("b2b_ld_done_valid", 64'(dataM.valid), 64'd1);
      chk("b2b_ld_result", dataM.result, 64'hA5A5_0000_FFFF_0001);
      next_cycle();
      drive(1'b1, 64'h0000_5678, 64'h0, MSIZE_D, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b_add2_stall", 64'(stallM), 64'd0);
      chk("b2b_add2_valid", 64'(dataM.valid), 64'd1);
      chk("b2b_add2_result", dataM.result, 64'h0000_5678);
      $display("txn back_to_back");

      next_cycle();
      dataE = '0;
      next_cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
